matrix_row_display: RTL and testbench

Downstream display stage for the stacker game FSM. Holds the 8×8 playfield as eight 8-bit row registers, written one row at a time through the FSM's `val`/`rowIndex`/`writeStrobe` outputs. Provides combinational read-back of any row to the FSM's `rowRead` input. Continuously time-multiplexes the stored rows onto an 8×8 LED matrix, with a blanking gap between rows to suppress ghosting.

---
 rtl/matrix_row_display_if.sv | 28 ++
 rtl/matrix_row_display.sv | 120 ++++++++++++
 tb/tb_matrix_row_display.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_row_display_if.sv
// FSM-side bus of the matrix row display: row writes, global clear and
// combinational row read-back.
interface matrix_row_display_if;
  logic [2:0] wrRow;
  logic [7:0] wrData;
  logic       writeStrobe;
  logic       clear;
  logic [2:0] rdRow;
  logic [7:0] rowRead;

  modport master (
    output wrRow,
    output wrData,
    output writeStrobe,
    output clear,
    output rdRow,
    input  rowRead
  );

  modport slave (
    input  wrRow,
    input  wrData,
    input  writeStrobe,
    input  clear,
    input  rdRow,
    output rowRead
  );
endinterface

// File: rtl/matrix_row_display.sv
// 8x8 playfield store with a blank/show row scanner driving an LED matrix.
// The pattern of a row is latched once when the row is lit, so writes land on the next visit.
module matrix_row_display #(
  parameter int DWELL = 1000,
  parameter int BLANK = 16
) (
  input  logic                       updateClk,
  input  logic                       reset,
  matrix_row_display_if.slave        bus,
  output logic [7:0]                 rowSel,
  output logic [7:0]                 colData,
  output logic                       frameTick
);

  localparam int MAXV = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(MAXV);
  localparam logic [CW-1:0] DWELL_TC  = CW'(DWELL - 1);
  localparam logic [CW-1:0] DWELL_PRE = CW'(DWELL - 2);
  localparam logic [CW-1:0] BLANK_TC  = CW'(BLANK - 1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  logic [7:0]    mem_q [8];
  logic [7:0]    mem_d [8];
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    scan_row_q, scan_row_d;
  logic [7:0]    row_sel_q, row_sel_d;
  logic [7:0]    col_data_q, col_data_d;
  logic          frame_tick_q, frame_tick_d;

  assign bus.rowRead = mem_q[bus.rdRow];
  assign rowSel      = row_sel_q;
  assign colData     = col_data_q;
  assign frameTick   = frame_tick_q;

  // Row storage update; clear wins over a simultaneous write.
  always_comb begin
    mem_d = mem_q;
    if (bus.clear) begin
      for (int i = 0; i < 8; i++) begin
        mem_d[i] = 8'h00;
      end
    end else if (bus.writeStrobe) begin
      mem_d[bus.wrRow] = bus.wrData;
    end else begin
      mem_d = mem_q;
    end
  end

  // Scanner next state; outputs are computed for the state being entered.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CW'(1);
    scan_row_d   = scan_row_q;
    row_sel_d    = row_sel_q;
    col_data_d   = col_data_q;
    frame_tick_d = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_TC) begin
          state_d    = ST_SHOW;
          cnt_d      = {CW{1'b0}};
          row_sel_d  = ~(8'h01 << scan_row_q);
          col_data_d = mem_q[scan_row_q];
        end else begin
          state_d = ST_BLANK;
        end
      end
      ST_SHOW: begin
        // Registered tick lands on the final cycle of row 7's dwell.
        frame_tick_d = (scan_row_q == 3'd7) && (cnt_q == DWELL_PRE);
        if (cnt_q == DWELL_TC) begin
          state_d    = ST_BLANK;
          cnt_d      = {CW{1'b0}};
          scan_row_d = scan_row_q + 3'd1;
          row_sel_d  = 8'hFF;
          col_data_d = 8'h00;
        end else begin
          state_d = ST_SHOW;
        end
      end
      default: begin
        state_d    = ST_BLANK;
        cnt_d      = {CW{1'b0}};
        row_sel_d  = 8'hFF;
        col_data_d = 8'h00;
      end
    endcase
  end

  // State, storage and output registers with synchronous reset.
  always_ff @(posedge updateClk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        mem_q[i] <= 8'h00;
      end
      state_q      <= ST_BLANK;
      cnt_q        <= {CW{1'b0}};
      scan_row_q   <= 3'd0;
      row_sel_q    <= 8'hFF;
      col_data_q   <= 8'h00;
      frame_tick_q <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        mem_q[i] <= mem_d[i];
      end
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      scan_row_q   <= scan_row_d;
      row_sel_q    <= row_sel_d;
      col_data_q   <= col_data_d;
      frame_tick_q <= frame_tick_d;
    end
  end

endmodule

// File: tb/tb_matrix_row_display.sv
// Bench for matrix_row_display: a slot-position display model feeds a scoreboard queue,
// a write/read vector table checks storage, and directed sequences cover the corner cases.
module tb_matrix_row_display;
  localparam int DW    = 4;
  localparam int BL    = 2;
  localparam int SLOT  = DW + BL;
  localparam int FRAME = 8 * SLOT;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rowSel;
  logic [7:0] colData;
  logic       frameTick;

  matrix_row_display_if bus();

  matrix_row_display #(.DWELL(DW), .BLANK(BL)) dut (
    .updateClk(clk),
    .reset(rst),
    .bus(bus),
    .rowSel(rowSel),
    .colData(colData),
    .frameTick(frameTick)
  );

  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] sel;
    logic [7:0] col;
    logic       tick;
  } exp_t;

  typedef struct {
    logic [2:0] wr_row;
    logic [7:0] wr_data;
    logic       strobe;
    logic       clr;
    logic [2:0] rd_row;
    logic [7:0] exp_old;
    logic [7:0] exp_new;
  } vec_t;

  exp_t       exp_q[$];
  logic [7:0] rd_q[$];
  exp_t       mon_e;
  exp_t       mdl_e;
  vec_t       vecs[8];

  // Reference model state: t is the cycle index since the last reset edge.
  int         t = 0;
  int         mk;
  int         mrow;
  logic [7:0] m_mem [8];
  logic [7:0] m_shown = 8'h00;
  logic [7:0] one8 = 8'h01;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h, expected %02h (t=%0d)", name, act, exp, t);
    end
  endtask

  // Display model: each slot is BL dark cycles then DW lit cycles; pattern latched on lighting.
  always @(posedge clk) begin
    if (rst) begin
      t = 0;
      m_shown = 8'h00;
      for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
    end else begin
      t = t + 1;
      mk = t % SLOT;
      mrow = (t / SLOT) % 8;
      if (mk == BL) m_shown = m_mem[mrow[2:0]];
      if (bus.clear) begin
        for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
      end else if (bus.writeStrobe) begin
        m_mem[bus.wrRow] = bus.wrData;
      end
    end
    mk = t % SLOT;
    mrow = (t / SLOT) % 8;
    if (rst || mk < BL) begin
      mdl_e.sel = 8'hFF;
      mdl_e.col = 8'h00;
    end else begin
      mdl_e.sel = ~(one8 << mrow);
      mdl_e.col = m_shown;
    end
    mdl_e.tick = !rst && (mrow == 7) && (mk == SLOT - 1);
    exp_q.push_back(mdl_e);
  end

  // Scoreboard: compare display outputs mid-cycle against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("rowSel", rowSel, mon_e.sel);
      chk("colData", colData, mon_e.col);
      chk("frameTick", {7'd0, frameTick}, {7'd0, mon_e.tick});
    end
  end

  task automatic wait_pos(input int p);
    int n = 0;
    while ((t % FRAME) != p && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 4 * FRAME) begin
      errors++;
      $display("FAIL wait_pos: position %0d not reached, t=%0d", p, t);
    end
  endtask

  task automatic write_row(input logic [2:0] r, input logic [7:0] d);
    bus.wrRow = r;
    bus.wrData = d;
    bus.writeStrobe = 1'b1;
    @(negedge clk);
    bus.writeStrobe = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks;
    logic [7:0] pat;
    rst = 1'b1;
    bus.wrRow = 3'd0;
    bus.wrData = 8'h00;
    bus.writeStrobe = 1'b0;
    bus.clear = 1'b0;
    bus.rdRow = 3'd0;

    vecs[0] = '{3'd3, 8'hE0, 1'b1, 1'b0, 3'd3, 8'h00, 8'hE0};
    vecs[1] = '{3'd0, 8'h01, 1'b1, 1'b0, 3'd0, 8'h00, 8'h01};
    vecs[2] = '{3'd1, 8'h02, 1'b1, 1'b0, 3'd0, 8'h01, 8'h01};
    vecs[3] = '{3'd1, 8'h02, 1'b0, 1'b0, 3'd1, 8'h02, 8'h02};
    vecs[4] = '{3'd1, 8'h55, 1'b0, 1'b0, 3'd1, 8'h02, 8'h02};
    vecs[5] = '{3'd5, 8'hFF, 1'b1, 1'b1, 3'd5, 8'h00, 8'h00};
    vecs[6] = '{3'd0, 8'h00, 1'b0, 1'b0, 3'd3, 8'h00, 8'h00};
    vecs[7] = '{3'd3, 8'hE0, 1'b1, 1'b0, 3'd3, 8'h00, 8'hE0};

    repeat (2) @(posedge clk);
    #1;
    for (int r = 0; r < 8; r++) begin
      bus.rdRow = 3'(r);
      #1 chk("reset_rowRead", bus.rowRead, 8'h00);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.rdRow = 3'd0;

    // Idle scan with an empty playfield: two frames give two ticks.
    ticks = 0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      if (frameTick === 1'b1) ticks++;
    end
    chk("idle_ticks", ticks[7:0], 8'd2);

    // Storage vectors: read value before and after the edge.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.wrRow = vecs[i].wr_row;
      bus.wrData = vecs[i].wr_data;
      bus.writeStrobe = vecs[i].strobe;
      bus.clear = vecs[i].clr;
      bus.rdRow = vecs[i].rd_row;
      #1 chk("rd_before_edge", bus.rowRead, vecs[i].exp_old);
      rd_q.push_back(vecs[i].exp_new);
      @(posedge clk);
      #1 chk("rd_after_edge", bus.rowRead, rd_q.pop_front());
    end
    @(negedge clk);
    bus.writeStrobe = 1'b0;
    bus.clear = 1'b0;

    // Row 3 holds E0 and is shown at its slot.
    wait_pos(0);
    wait_pos(3 * SLOT + 3);
    chk("row3_sel", rowSel, 8'hF7);
    chk("row3_col", colData, 8'hE0);

    // Rewrite row 2 while it is lit: old pattern holds for the dwell.
    write_row(3'd2, 8'h70);
    wait_pos(0);
    wait_pos(2 * SLOT + 3);
    chk("row2_old", colData, 8'h70);
    bus.wrRow = 3'd2;
    bus.wrData = 8'h1C;
    bus.writeStrobe = 1'b1;
    @(negedge clk);
    bus.writeStrobe = 1'b0;
    chk("row2_hold", colData, 8'h70);
    bus.rdRow = 3'd2;
    #1 chk("row2_readback", bus.rowRead, 8'h1C);
    wait_pos(2 * SLOT + 5);
    chk("row2_hold_end", colData, 8'h70);
    wait_pos(2 * SLOT + 3);
    chk("row2_new", colData, 8'h1C);

    // Walking-one rows: full-frame wrap and tick alignment.
    for (int i = 0; i < 8; i++) begin
      pat = one8 << i;
      write_row(3'(i), pat);
    end
    wait_pos(0);
    for (int r = 0; r < 8; r++) begin
      wait_pos(r * SLOT + BL);
      pat = one8 << r;
      chk("walk_col", colData, pat);
    end
    wait_pos(FRAME - 1);
    chk("tick_at_row7_end", {7'd0, frameTick}, 8'h01);
    chk("tick_row7_sel", rowSel, 8'h7F);
    wait_pos(BL);
    chk("wrap_col", colData, 8'h01);
    ticks = 0;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      if (frameTick === 1'b1) ticks++;
    end
    chk("frame_ticks", ticks[7:0], 8'd1);

    // Fill with AA, then reset in the middle of row 6's dwell.
    for (int i = 0; i < 8; i++) write_row(3'(i), 8'hAA);
    wait_pos(0);
    wait_pos(6 * SLOT + 3);
    chk("row6_lit", colData, 8'hAA);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_sel", rowSel, 8'hFF);
    chk("rst_col", colData, 8'h00);
    for (int r = 0; r < 8; r++) begin
      bus.rdRow = 3'(r);
      #1 chk("rst_mid_rowRead", bus.rowRead, 8'h00);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("restart_row0", rowSel, 8'hFE);
    chk("restart_col", colData, 8'h00);

    repeat (FRAME + 4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
